// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the ID/EX operand stage and the ALU:
//   - forwarding select codes driven by the hazard unit
//   - ALU select codes (5-bit) and the highest legal code
//   - bit positions inside the 4-bit control bundle
// ---------------------------------------------------------------------------
package pipeline_pkg;

   // Forwarding selects; 2'b11 is reserved and behaves like FWD_REG.
   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   // ALU select codes.
   localparam logic [4:0] ALU_ADD    = 5'b00000;
   localparam logic [4:0] ALU_SUB    = 5'b00001;
   localparam logic [4:0] ALU_AND    = 5'b00010;
   localparam logic [4:0] ALU_OR     = 5'b00011;
   localparam logic [4:0] ALU_XOR    = 5'b00100;
   localparam logic [4:0] ALU_SLL    = 5'b00101;
   localparam logic [4:0] ALU_SRL    = 5'b00110;
   localparam logic [4:0] ALU_SRA    = 5'b00111;
   localparam logic [4:0] ALU_SLT    = 5'b01000;
   localparam logic [4:0] ALU_SLTU   = 5'b01001;
   localparam logic [4:0] ALU_MUL    = 5'b01010;
   localparam logic [4:0] ALU_MULH   = 5'b01011;
   localparam logic [4:0] ALU_MULHSU = 5'b01100;
   localparam logic [4:0] ALU_MULHU  = 5'b01101;
   localparam logic [4:0] ALU_DIV    = 5'b01110;
   localparam logic [4:0] ALU_DIVU   = 5'b01111;
   localparam logic [4:0] ALU_REM    = 5'b10000;
   localparam logic [4:0] ALU_REMU   = 5'b10001;
   localparam logic [4:0] ALU_SEL_MAX = ALU_REMU;

   // Control bundle layout: {REG_WRITE, MEM_READ, MEM_WRITE, WB_SEL}.
   localparam int CTRL_W         = 4;
   localparam int CTRL_REG_WRITE = 3;
   localparam int CTRL_MEM_READ  = 2;
   localparam int CTRL_MEM_WRITE = 1;
   localparam int CTRL_WB_SEL    = 0;

endpackage

// File: rtl/fwd_mux3.sv
// ---------------------------------------------------------------------------
// fwd_mux3
// XLEN-wide 3:1 forwarding selector (purely combinational).
// Ports:
//   sel        - forwarding select (FWD_REG / FWD_EXMEM / FWD_MEMWB, 11 = reg)
//   reg_data   - operand value captured in the ID/EX register
//   exmem_data - result currently held in EX/MEM
//   memwb_data - result currently held in MEM/WB
//   fwd_data   - selected operand
// ---------------------------------------------------------------------------
module fwd_mux3
   import pipeline_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [1:0]      sel,
   input  logic [XLEN-1:0] reg_data,
   input  logic [XLEN-1:0] exmem_data,
   input  logic [XLEN-1:0] memwb_data,
   output logic [XLEN-1:0] fwd_data
);

   always_comb begin
      fwd_data = reg_data;
      case (sel)
         FWD_EXMEM: fwd_data = exmem_data;
         FWD_MEMWB: fwd_data = memwb_data;
         default:   fwd_data = reg_data;
      endcase
   end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// id_ex_operand_stage
// ID/EX pipeline register followed by the EX-side operand selection that
// feeds the ALU directly.
// Ports:
//   CLK, RESET          - rising-edge clock, asynchronous active-low reset
//   HOLD, FLUSH         - stall (keep contents) / bubble insertion, FLUSH wins
//   ID_*                - decoded instruction fields captured at end of ID
//   FWD1_SEL, FWD2_SEL  - hazard-unit forwarding selects for rs1 / rs2
//   EXMEM_RESULT,
//   MEMWB_RESULT        - results available for forwarding
//   ALU_DATA1/2, ALU_SELECT - final ALU operands and operation
//   STORE_DATA          - forwarded rs2 for the MEM stage
//   EX_RD, EX_CTRL, EX_VALID - registered destination, control, valid
//   EX_ILLEGAL          - valid entry carries an unused select code
// ---------------------------------------------------------------------------
module id_ex_operand_stage #(
   parameter int XLEN       = 32,
   parameter int SEL_W      = 5,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  HOLD,
   input  logic                  FLUSH,
   input  logic                  ID_VALID,
   input  logic [XLEN-1:0]       ID_RS1_DATA,
   input  logic [XLEN-1:0]       ID_RS2_DATA,
   input  logic [XLEN-1:0]       ID_IMM,
   input  logic [XLEN-1:0]       ID_PC,
   input  logic [SEL_W-1:0]      ID_SELECT,
   input  logic [REG_ADDR_W-1:0] ID_RD,
   input  logic [3:0]            ID_CTRL,
   input  logic                  ID_IMM_SEL,
   input  logic                  ID_PC_SEL,
   input  logic [1:0]            FWD1_SEL,
   input  logic [1:0]            FWD2_SEL,
   input  logic [XLEN-1:0]       EXMEM_RESULT,
   input  logic [XLEN-1:0]       MEMWB_RESULT,
   output logic [XLEN-1:0]       ALU_DATA1,
   output logic [XLEN-1:0]       ALU_DATA2,
   output logic [SEL_W-1:0]      ALU_SELECT,
   output logic [XLEN-1:0]       STORE_DATA,
   output logic [REG_ADDR_W-1:0] EX_RD,
   output logic [3:0]            EX_CTRL,
   output logic                  EX_VALID,
   output logic                  EX_ILLEGAL
);

   import pipeline_pkg::*;

   logic                  vld_p1;
   logic [XLEN-1:0]       rs1_p1;
   logic [XLEN-1:0]       rs2_p1;
   logic [XLEN-1:0]       imm_p1;
   logic [XLEN-1:0]       pc_p1;
   logic [SEL_W-1:0]      sel_p1;
   logic [REG_ADDR_W-1:0] rd_p1;
   logic [3:0]            ctrl_p1;
   logic                  imm_sel_p1;
   logic                  pc_sel_p1;

   logic [XLEN-1:0]       fwd_rs1;
   logic [XLEN-1:0]       fwd_rs2;

   // ---- ID -> EX boundary: pipeline register ------------------------------
   // A bubble only needs its control side cleared; the data words are
   // don't-care once VALID/CTRL are zero, so they load as usual.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         vld_p1     <= 1'b0;
         rs1_p1     <= '0;
         rs2_p1     <= '0;
         imm_p1     <= '0;
         pc_p1      <= '0;
         sel_p1     <= '0;
         rd_p1      <= '0;
         ctrl_p1    <= '0;
         imm_sel_p1 <= 1'b0;
         pc_sel_p1  <= 1'b0;
      end else if (FLUSH) begin
         vld_p1     <= 1'b0;
         sel_p1     <= SEL_W'(ALU_ADD);
         rd_p1      <= '0;
         ctrl_p1    <= '0;
         imm_sel_p1 <= 1'b0;
         pc_sel_p1  <= 1'b0;
         rs1_p1     <= ID_RS1_DATA;
         rs2_p1     <= ID_RS2_DATA;
         imm_p1     <= ID_IMM;
         pc_p1      <= ID_PC;
      end else if (!HOLD) begin
         vld_p1     <= ID_VALID;
         rs1_p1     <= ID_RS1_DATA;
         rs2_p1     <= ID_RS2_DATA;
         imm_p1     <= ID_IMM;
         pc_p1      <= ID_PC;
         sel_p1     <= ID_SELECT;
         rd_p1      <= ID_RD;
         // An invalid slot must never write back or touch memory.
         ctrl_p1    <= ID_VALID ? ID_CTRL : 4'b0000;
         imm_sel_p1 <= ID_IMM_SEL;
         pc_sel_p1  <= ID_PC_SEL;
      end
   end

   // ---- EX: combinational forwarding and operand selection ----------------
   fwd_mux3 #(.XLEN(XLEN)) u_fwd_rs1 (
      .sel        (FWD1_SEL),
      .reg_data   (rs1_p1),
      .exmem_data (EXMEM_RESULT),
      .memwb_data (MEMWB_RESULT),
      .fwd_data   (fwd_rs1)
   );

   fwd_mux3 #(.XLEN(XLEN)) u_fwd_rs2 (
      .sel        (FWD2_SEL),
      .reg_data   (rs2_p1),
      .exmem_data (EXMEM_RESULT),
      .memwb_data (MEMWB_RESULT),
      .fwd_data   (fwd_rs2)
   );

   assign ALU_DATA1  = pc_sel_p1  ? pc_p1  : fwd_rs1;
   assign ALU_DATA2  = imm_sel_p1 ? imm_p1 : fwd_rs2;
   // Stores always need the real rs2 value, even when DATA2 carries the offset.
   assign STORE_DATA = fwd_rs2;
   assign ALU_SELECT = sel_p1;
   assign EX_RD      = rd_p1;
   assign EX_CTRL    = ctrl_p1;
   assign EX_VALID   = vld_p1;
   assign EX_ILLEGAL = vld_p1 && (sel_p1 > SEL_W'(ALU_SEL_MAX));

endmodule

// File: tb/tb_id_ex_operand_stage.sv
module tb_id_ex_operand_stage;

   logic        CLK;
   logic        RESET;
   logic        HOLD;
   logic        FLUSH;
   logic        ID_VALID;
   logic [31:0] ID_RS1_DATA;
   logic [31:0] ID_RS2_DATA;
   logic [31:0] ID_IMM;
   logic [31:0] ID_PC;
   logic [4:0]  ID_SELECT;
   logic [4:0]  ID_RD;
   logic [3:0]  ID_CTRL;
   logic        ID_IMM_SEL;
   logic        ID_PC_SEL;
   logic [1:0]  FWD1_SEL;
   logic [1:0]  FWD2_SEL;
   logic [31:0] EXMEM_RESULT;
   logic [31:0] MEMWB_RESULT;
   logic [31:0] ALU_DATA1;
   logic [31:0] ALU_DATA2;
   logic [4:0]  ALU_SELECT;
   logic [31:0] STORE_DATA;
   logic [4:0]  EX_RD;
   logic [3:0]  EX_CTRL;
   logic        EX_VALID;
   logic        EX_ILLEGAL;

   id_ex_operand_stage #(.XLEN(32), .SEL_W(5), .REG_ADDR_W(5)) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .HOLD         (HOLD),
      .FLUSH        (FLUSH),
      .ID_VALID     (ID_VALID),
      .ID_RS1_DATA  (ID_RS1_DATA),
      .ID_RS2_DATA  (ID_RS2_DATA),
      .ID_IMM       (ID_IMM),
      .ID_PC        (ID_PC),
      .ID_SELECT    (ID_SELECT),
      .ID_RD        (ID_RD),
      .ID_CTRL      (ID_CTRL),
      .ID_IMM_SEL   (ID_IMM_SEL),
      .ID_PC_SEL    (ID_PC_SEL),
      .FWD1_SEL     (FWD1_SEL),
      .FWD2_SEL     (FWD2_SEL),
      .EXMEM_RESULT (EXMEM_RESULT),
      .MEMWB_RESULT (MEMWB_RESULT),
      .ALU_DATA1    (ALU_DATA1),
      .ALU_DATA2    (ALU_DATA2),
      .ALU_SELECT   (ALU_SELECT),
      .STORE_DATA   (STORE_DATA),
      .EX_RD        (EX_RD),
      .EX_CTRL      (EX_CTRL),
      .EX_VALID     (EX_VALID),
      .EX_ILLEGAL   (EX_ILLEGAL)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // mask bits: 0 d1, 1 d2, 2 store, 3 sel, 4 rd, 5 ctrl, 6 valid, 7 illegal
   typedef struct {
      string       name;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] st;
      logic [4:0]  sel;
      logic [4:0]  rd;
      logic [3:0]  ctrl;
      logic        vld;
      logic        ill;
      logic [7:0]  m;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic push(input string nm, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] st, input logic [4:0] sel, input logic [4:0] rd,
                       input logic [3:0] ctrl, input logic vld, input logic ill,
                       input logic [7:0] m);
      exp_t e;
      e.name = nm; e.d1 = d1; e.d2 = d2; e.st = st; e.sel = sel; e.rd = rd;
      e.ctrl = ctrl; e.vld = vld; e.ill = ill; e.m = m;
      sb.push_back(e);
   endtask

   // Monitor: outputs are sampled on the falling edge, away from capture.
   always @(negedge CLK) begin
      while (sb.size() > 0) begin
         mon_e = sb.pop_front();
         if (mon_e.m[0]) chk({mon_e.name, ".data1"},   ALU_DATA1,       mon_e.d1);
         if (mon_e.m[1]) chk({mon_e.name, ".data2"},   ALU_DATA2,       mon_e.d2);
         if (mon_e.m[2]) chk({mon_e.name, ".store"},   STORE_DATA,      mon_e.st);
         if (mon_e.m[3]) chk({mon_e.name, ".select"},  32'(ALU_SELECT), 32'(mon_e.sel));
         if (mon_e.m[4]) chk({mon_e.name, ".rd"},      32'(EX_RD),      32'(mon_e.rd));
         if (mon_e.m[5]) chk({mon_e.name, ".ctrl"},    32'(EX_CTRL),    32'(mon_e.ctrl));
         if (mon_e.m[6]) chk({mon_e.name, ".valid"},   32'(EX_VALID),   32'(mon_e.vld));
         if (mon_e.m[7]) chk({mon_e.name, ".illegal"}, 32'(EX_ILLEGAL), 32'(mon_e.ill));
      end
   end

   task automatic cycle();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET = 1'b0; HOLD = 1'b0; FLUSH = 1'b0; ID_VALID = 1'b0;
      ID_RS1_DATA = '0; ID_RS2_DATA = '0; ID_IMM = '0; ID_PC = '0;
      ID_SELECT = '0; ID_RD = '0; ID_CTRL = '0; ID_IMM_SEL = 1'b0; ID_PC_SEL = 1'b0;
      FWD1_SEL = 2'b00; FWD2_SEL = 2'b00; EXMEM_RESULT = '0; MEMWB_RESULT = '0;

      cycle();
      push("rst_init", 0, 0, 0, 0, 0, 4'h0, 0, 0, 8'hFF);
      cycle();
      RESET = 1'b1;

      // Live instruction, then reset asserted between edges.
      ID_VALID = 1'b1; ID_CTRL = 4'hF; ID_RS1_DATA = 32'd11; ID_RS2_DATA = 32'd22;
      ID_SELECT = 5'd3; ID_RD = 5'd4;
      cycle();
      push("load_a", 32'd11, 32'd22, 32'd22, 5'd3, 5'd4, 4'hF, 1, 0, 8'hFF);
      cycle();
      RESET = 1'b0;
      push("rst_async", 0, 0, 0, 0, 0, 4'h0, 0, 0, 8'hFF);
      cycle();
      RESET = 1'b1;

      // Plain load.
      ID_RS1_DATA = 32'd25; ID_RS2_DATA = 32'd20; ID_SELECT = 5'b00001; ID_RD = 5'd5;
      ID_CTRL = 4'h8; ID_PC = 32'h100; ID_IMM = 32'h33;
      cycle();
      push("load_b", 32'd25, 32'd20, 32'd20, 5'd1, 5'd5, 4'h8, 1, 0, 8'hFF);
      cycle();

      // Stall for three edges while ID changes; forwarding still tracks.
      HOLD = 1'b1; EXMEM_RESULT = 32'd100; MEMWB_RESULT = 32'd7; FWD1_SEL = 2'b01;
      ID_RS1_DATA = 32'd99; ID_RS2_DATA = 32'd98; ID_SELECT = 5'd7; ID_RD = 5'd9; ID_CTRL = 4'h3;
      push("fwd1_exmem", 32'd100, 32'd20, 32'd20, 5'd1, 5'd5, 4'h8, 1, 0, 8'hFF);
      cycle();
      FWD1_SEL = 2'b10; FWD2_SEL = 2'b10;
      push("fwd_memwb", 32'd7, 32'd7, 32'd7, 5'd1, 5'd5, 4'h8, 1, 0, 8'hFF);
      cycle();
      FWD1_SEL = 2'b11; FWD2_SEL = 2'b11; ID_RS1_DATA = 32'd55; ID_VALID = 1'b0;
      push("fwd_rsvd", 32'd25, 32'd20, 32'd20, 5'd1, 5'd5, 4'h8, 1, 0, 8'hFF);
      cycle();
      FWD1_SEL = 2'b00; FWD2_SEL = 2'b00;
      push("hold3", 32'd25, 32'd20, 32'd20, 5'd1, 5'd5, 4'h8, 1, 0, 8'hFF);
      HOLD = 1'b0;

      // Immediate and PC operand muxes; store data still forwarded rs2.
      ID_VALID = 1'b1; ID_RS1_DATA = 32'd25; ID_RS2_DATA = 32'd20; ID_IMM = 32'hFFFF_FFF0;
      ID_IMM_SEL = 1'b1; ID_PC_SEL = 1'b1; ID_PC = 32'h100; ID_SELECT = 5'd0;
      ID_RD = 5'd6; ID_CTRL = 4'h4;
      cycle();
      FWD2_SEL = 2'b01; EXMEM_RESULT = 32'd9;
      push("imm_pc", 32'h100, 32'hFFFF_FFF0, 32'd9, 5'd0, 5'd6, 4'h4, 1, 0, 8'hFF);
      cycle();

      // Flush beats hold.
      FLUSH = 1'b1; HOLD = 1'b1; ID_SELECT = 5'd9;
      cycle();
      FLUSH = 1'b0; HOLD = 1'b0;
      push("flush", 0, 0, 0, 5'd0, 5'd0, 4'h0, 0, 0, 8'hF8);

      // Illegal select code, valid then invalid, then the top legal code.
      FWD2_SEL = 2'b00; ID_IMM_SEL = 1'b0; ID_PC_SEL = 1'b0;
      ID_SELECT = 5'b10010; ID_VALID = 1'b1; ID_CTRL = 4'hF; ID_RD = 5'd7;
      ID_RS1_DATA = 32'd1; ID_RS2_DATA = 32'd2;
      cycle();
      push("illegal_v", 32'd1, 32'd2, 32'd2, 5'b10010, 5'd7, 4'hF, 1, 1, 8'hFF);
      ID_VALID = 1'b0;
      cycle();
      push("illegal_nv", 0, 0, 0, 5'b10010, 5'd0, 4'h0, 0, 0, 8'hE8);
      ID_VALID = 1'b1; ID_SELECT = 5'b10001; ID_CTRL = 4'h2;
      cycle();
      push("sel_max", 32'd1, 32'd2, 32'd2, 5'b10001, 5'd7, 4'h2, 1, 0, 8'hFF);

      cycle();
      cycle();
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
